// File: rtl/led_blink_sequencer.sv
// Blink-pattern scheduler: steps a variable clock divider through a table of
// (divisor, toggle-count) entries, switching divisor only on a divider toggle.
module led_blink_sequencer #(
  parameter int unsigned      WIDTH    = 8,
  parameter int unsigned      DEPTH    = 8,
  parameter int unsigned      CNT_W    = 8,
  parameter logic [WIDTH-1:0] IDLE_DIV = '1
) (
  input  logic                     clk_in,
  input  logic                     glb_reset,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic [WIDTH-1:0]         cfg_divisor,
  input  logic [CNT_W-1:0]         cfg_toggles,
  input  logic [$clog2(DEPTH):0]   seq_len,
  input  logic                     loop_en,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     div_tick,
  output logic [WIDTH-1:0]         divisor,
  output logic                     busy,
  output logic [$clog2(DEPTH)-1:0] step_idx,
  output logic                     seq_done,
  output logic                     cfg_err
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] LEN_MAX = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic               tick_q;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic [AW-1:0]      step_q, step_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [AW:0]        len_q, len_d;
  logic               loop_q, loop_d;
  logic               seq_done_q, seq_done_d;
  logic               cfg_err_q, cfg_err_d;
  logic [WIDTH-1:0]   tbl_div_q [DEPTH];
  logic [WIDTH-1:0]   tbl_div_d [DEPTH];
  logic [CNT_W-1:0]   tbl_tog_q [DEPTH];
  logic [CNT_W-1:0]   tbl_tog_d [DEPTH];

  logic               toggle;
  logic               len_ok;
  logic               last_step;
  logic [AW-1:0]      load_idx;
  logic [WIDTH-1:0]   ld_div;
  logic [CNT_W-1:0]   ld_tog;

  assign toggle    = div_tick ^ tick_q;
  assign len_ok    = (seq_len != '0) && (seq_len <= LEN_MAX);
  assign last_step = ({1'b0, step_q} == (len_q - 1'b1));

  // Step to load on the next boundary, with zero entries promoted to 1.
  always_comb begin
    load_idx = '0;
    if (state_q == StRun && !last_step) begin
      load_idx = step_q + 1'b1;
    end
    ld_div = (tbl_div_q[load_idx] == '0) ? WIDTH'(1) : tbl_div_q[load_idx];
    ld_tog = (tbl_tog_q[load_idx] == '0) ? CNT_W'(1) : tbl_tog_q[load_idx];
  end

  // Table writes are accepted only while idle.
  always_comb begin
    tbl_div_d = tbl_div_q;
    tbl_tog_d = tbl_tog_q;
    if (cfg_we && state_q == StIdle) begin
      tbl_div_d[cfg_addr] = cfg_divisor;
      tbl_tog_d[cfg_addr] = cfg_toggles;
    end
  end

  // Sequencer next-state; stop overrides everything in the active states.
  always_comb begin
    state_d    = state_q;
    divisor_d  = divisor_q;
    step_d     = step_q;
    rem_d      = rem_q;
    len_d      = len_q;
    loop_d     = loop_q;
    seq_done_d = 1'b0;
    cfg_err_d  = cfg_we && (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (!len_ok) begin
            cfg_err_d = 1'b1;
          end else if (!stop) begin
            len_d   = seq_len;
            loop_d  = loop_en;
            step_d  = '0;
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (stop) begin
          state_d   = StIdle;
          divisor_d = IDLE_DIV;
          step_d    = '0;
        end else if (toggle) begin
          divisor_d = ld_div;
          rem_d     = ld_tog;
          step_d    = '0;
          state_d   = StRun;
        end
      end
      StRun: begin
        if (stop) begin
          state_d   = StIdle;
          divisor_d = IDLE_DIV;
          step_d    = '0;
        end else if (toggle) begin
          if (rem_q > CNT_W'(1)) begin
            rem_d = rem_q - 1'b1;
          end else if (!last_step || loop_q) begin
            step_d    = load_idx;
            divisor_d = ld_div;
            rem_d     = ld_tog;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d   = StIdle;
        divisor_d = IDLE_DIV;
        step_d    = '0;
        seq_done_d = !stop;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and table registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (glb_reset) begin
      state_q    <= StIdle;
      tick_q     <= 1'b0;
      divisor_q  <= IDLE_DIV;
      step_q     <= '0;
      rem_q      <= '0;
      len_q      <= '0;
      loop_q     <= 1'b0;
      seq_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_div_q[i] <= '0;
        tbl_tog_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      tick_q     <= div_tick;
      divisor_q  <= divisor_d;
      step_q     <= step_d;
      rem_q      <= rem_d;
      len_q      <= len_d;
      loop_q     <= loop_d;
      seq_done_q <= seq_done_d;
      cfg_err_q  <= cfg_err_d;
      tbl_div_q  <= tbl_div_d;
      tbl_tog_q  <= tbl_tog_d;
    end
  end

  assign divisor  = divisor_q;
  assign busy     = (state_q == StLoad) || (state_q == StRun);
  assign step_idx = step_q;
  assign seq_done = seq_done_q;
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Bench for led_blink_sequencer: a behavioural divider closes the loop, and the
// divisor in force after every divider toggle is compared with the table expansion.
module tb_led_blink_sequencer;

  localparam int D = 8;

  logic       clk = 1'b0;
  logic       glb_reset = 1'b1;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [7:0] cfg_divisor = '0;
  logic [7:0] cfg_toggles = '0;
  logic [3:0] seq_len = '0;
  logic       loop_en = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       div_tick = 1'b0;
  logic [7:0] divisor;
  logic       busy;
  logic [2:0] step_idx;
  logic       seq_done;
  logic       cfg_err;

  always #5 clk = ~clk;

  led_blink_sequencer dut (
    .clk_in      (clk),
    .glb_reset   (glb_reset),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_divisor (cfg_divisor),
    .cfg_toggles (cfg_toggles),
    .seq_len     (seq_len),
    .loop_en     (loop_en),
    .start       (start),
    .stop        (stop),
    .div_tick    (div_tick),
    .divisor     (divisor),
    .busy        (busy),
    .step_idx    (step_idx),
    .seq_done    (seq_done),
    .cfg_err     (cfg_err)
  );

  // Divider: output flips once every `divisor` clocks.
  logic [7:0] dcnt = '0;
  always @(posedge clk) begin
    if (glb_reset) begin
      dcnt     <= '0;
      div_tick <= 1'b0;
    end else if (int'(dcnt) + 1 >= int'(divisor)) begin
      dcnt     <= '0;
      div_tick <= ~div_tick;
    end else begin
      dcnt <= dcnt + 1'b1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Log the divisor one cycle after each divider toggle, tagged by toggle cycle.
  int   log_div[$];
  int   log_cyc[$];
  bit   pend = 0;
  int   pend_cyc = 0;
  logic last_tick = 1'b0;
  int   done_cnt = 0;
  always @(negedge clk) begin
    if (pend) begin
      log_div.push_back(int'(divisor));
      log_cyc.push_back(pend_cyc);
    end
    pend      = (div_tick !== last_tick);
    pend_cyc  = cyc;
    last_tick = div_tick;
    if (seq_done === 1'b1) done_cnt++;
  end

  int n_total = 0;
  int n_bad   = 0;
  int m_div[D];
  int m_tog[D];
  int exp_q[$];
  int got_q[$];
  int start_cyc = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int n_after();
    int c = 0;
    foreach (log_cyc[i]) if (log_cyc[i] > start_cyc) c++;
    return c;
  endfunction

  function automatic void collect();
    got_q.delete();
    foreach (log_cyc[i]) if (log_cyc[i] > start_cyc) got_q.push_back(log_div[i]);
  endfunction

  // Divisor after each toggle: every step repeated max(tog,1) times at max(div,1);
  // the final toggle leaves the divisor as is until the sequence drops to idle.
  function automatic void build_exp(input int len);
    exp_q.delete();
    for (int s = 0; s < len; s++) begin
      for (int t = 0; t < ((m_tog[s] == 0) ? 1 : m_tog[s]); t++) begin
        exp_q.push_back((m_div[s] == 0) ? 1 : m_div[s]);
      end
    end
    exp_q.push_back(exp_q[exp_q.size() - 1]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < D; i++) begin
      m_div[i] = 0;
      m_tog[i] = 0;
    end
  endtask

  task automatic cfg_write(input int a, input int dv, input int tg);
    cfg_we = 1'b1; cfg_addr = 3'(a); cfg_divisor = 8'(dv); cfg_toggles = 8'(tg);
    tick();
    cfg_we = 1'b0;
    m_div[a] = dv;
    m_tog[a] = tg;
    check_eq("idle_write_err", int'(cfg_err), 0);
  endtask

  task automatic start_seq(input int len, input bit lp);
    seq_len = 4'(len); loop_en = lp; start = 1'b1;
    start_cyc = cyc;
    done_cnt  = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_toggles(input int n);
    bit ok = 0;
    for (int k = 0; k < 2000; k++) begin
      if (n_after() >= n) begin
        ok = 1;
        break;
      end
      tick();
    end
    check_eq("wait_toggles", int'(ok), 1);
  endtask

  task automatic finish_seq(input string tag);
    bit seen = 0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      tick();
      if (seq_done === 1'b1) seen = 1;
    end
    check_eq({tag, "_done_seen"}, int'(seen), 1);
    check_eq({tag, "_busy"}, int'(busy), 0);
    check_eq({tag, "_idle_div"}, int'(divisor), 255);
    check_eq({tag, "_step"}, int'(step_idx), 0);
    collect();
    check_eq({tag, "_enough_toggles"}, int'(got_q.size() >= exp_q.size()), 1);
    foreach (got_q[i]) begin
      check_eq($sformatf("%s_div[%0d]", tag, i), got_q[i],
               (i < exp_q.size()) ? exp_q[i] : 255);
    end
    repeat (3) tick();
    check_eq({tag, "_done_once"}, done_cnt, 1);
  endtask

  initial begin
    int prev_step;
    int wraps;
    int n;
    logic prev_tick;

    model_clear();
    repeat (3) tick();
    glb_reset = 1'b0;
    tick();

    // Reset state
    check_eq("rst_div", int'(divisor), 255);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_err", int'(cfg_err), 0);
    check_eq("rst_step", int'(step_idx), 0);
    check_eq("rst_done", int'(seq_done), 0);

    // Reset held mid-run
    cfg_write(0, 2, 3);
    cfg_write(1, 5, 2);
    start_seq(2, 0);
    wait_toggles(2);
    check_eq("run_busy", int'(busy), 1);
    glb_reset = 1'b1;
    for (int r = 0; r < 2; r++) begin
      tick();
      check_eq("midrst_div", int'(divisor), 255);
      check_eq("midrst_busy", int'(busy), 0);
      check_eq("midrst_err", int'(cfg_err), 0);
      check_eq("midrst_step", int'(step_idx), 0);
    end
    glb_reset = 1'b0;
    model_clear();
    repeat (3) tick();
    check_eq("midrst_no_done", done_cnt, 0);

    // Two-step one-shot sequence
    cfg_write(0, 2, 3);
    cfg_write(1, 5, 2);
    start_seq(2, 0);
    build_exp(2);
    finish_seq("oneshot");

    // Looping sequence: pattern repeats, step wraps, never done
    start_seq(2, 1);
    build_exp(2);
    void'(exp_q.pop_back());
    wraps = 0;
    prev_step = int'(step_idx);
    for (int k = 0; k < 3000 && n_after() < 12; k++) begin
      tick();
      if (prev_step == 1 && int'(step_idx) == 0) wraps++;
      prev_step = int'(step_idx);
    end
    collect();
    check_eq("loop_count", int'(got_q.size() >= 12), 1);
    for (int i = 0; i < 12 && i < got_q.size(); i++) begin
      check_eq($sformatf("loop_div[%0d]", i), got_q[i], exp_q[i % exp_q.size()]);
    end
    check_eq("loop_wrapped", int'(wraps >= 1), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("loop_stop_busy", int'(busy), 0);
    check_eq("loop_stop_div", int'(divisor), 255);
    check_eq("loop_stop_step", int'(step_idx), 0);
    repeat (3) tick();
    check_eq("loop_no_done", done_cnt, 0);

    // Rejected lengths
    for (int j = 0; j < 2; j++) begin
      seq_len = (j == 0) ? 4'd0 : 4'd9;
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq($sformatf("badlen%0d_err", j), int'(cfg_err), 1);
      check_eq($sformatf("badlen%0d_busy", j), int'(busy), 0);
      tick();
      check_eq($sformatf("badlen%0d_err_clr", j), int'(cfg_err), 0);
      check_eq($sformatf("badlen%0d_idle", j), int'(busy), 0);
    end

    // Zero entry runs at divisor 1 for a single toggle
    cfg_write(0, 0, 0);
    cfg_write(1, 3, 1);
    start_seq(2, 0);
    build_exp(2);
    finish_seq("zero_entry");

    // Write and start while running
    cfg_write(0, 2, 3);
    cfg_write(1, 5, 2);
    start_seq(2, 0);
    build_exp(2);
    wait_toggles(2);
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_divisor = 8'd7; cfg_toggles = 8'd7;
    tick();
    cfg_we = 1'b0;
    check_eq("busy_write_err", int'(cfg_err), 1);
    seq_len = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("busy_start_err", int'(cfg_err), 0);
    check_eq("busy_start_busy", int'(busy), 1);
    finish_seq("busy_cfg");
    start_seq(2, 0);
    finish_seq("readback");

    // Stop coincident with the final toggle
    cfg_write(0, 3, 2);
    start_seq(1, 0);
    n = 0;
    prev_tick = last_tick;
    prev_tick = div_tick;
    for (int k = 0; k < 2000; k++) begin
      tick();
      if (div_tick !== prev_tick) begin
        n++;
        prev_tick = div_tick;
        if (n == 3) break;
      end
    end
    check_eq("stop_final_seen", n, 3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("stop_final_busy", int'(busy), 0);
    check_eq("stop_final_div", int'(divisor), 255);
    check_eq("stop_final_step", int'(step_idx), 0);
    check_eq("stop_final_done", int'(seq_done), 0);
    repeat (4) tick();
    check_eq("stop_final_no_done", done_cnt, 0);

    // Randomized tables and lengths
    for (int r = 0; r < 10; r++) begin
      int len;
      for (int a = 0; a < D; a++) begin
        cfg_write(a, int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
      end
      len = int'($urandom_range(1, 8));
      start_seq(len, 0);
      build_exp(len);
      finish_seq($sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
